// File: rtl/id_hazard_stage.sv
// Instruction-decode stage: RAW hazard detection, EX/MEM/WB operand forwarding,
// load-use bubbles and the ID/EX pipeline register with back-pressure and flush.
module id_hazard_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CTRL_W    = 24,
  parameter int unsigned EX_FWD    = 1,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_b,

  input  logic              id_pipe_valid,
  output logic              id_pipe_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_instruction,

  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              dec_rs1_read,
  input  logic              dec_rs2_read,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic              dec_rd_write,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic              dec_mem_read,
  input  logic [XLEN-1:0]   dec_immediate,

  input  logic [XLEN-1:0]   rf_rs1_rdata,
  input  logic [XLEN-1:0]   rf_rs2_rdata,

  input  logic              ex_pipe_ready,
  output logic              ex_pipe_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_instruction,
  output logic [XLEN-1:0]   ex_immediate,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1_rdata,
  output logic [XLEN-1:0]   ex_rs2_rdata,
  output logic              ex_rd_write,
  output logic              ex_mem_read,
  output logic [REG_AW-1:0] ex_rd_addr,

  input  logic [XLEN-1:0]   ex_fwd_data,

  input  logic              mem_rd_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_rd_wdata,

  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_wdata,

  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic EX_FWD_EN = (EX_FWD != 0);
  localparam logic WB_BYP_EN = (WB_BYPASS != 0);

  logic            ex_src_write;
  logic            ex_hit_rs1;
  logic            ex_hit_rs2;
  logic            mem_hit_rs1;
  logic            mem_hit_rs2;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            ex_dep_stalls;
  logic            hazard;
  logic            stall_event;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;

  // A producer matches a source only if the source is really read and is not x0.
  function automatic logic src_match(input logic              used,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              wr,
                                     input logic [REG_AW-1:0] wa);
    return used & (rs != '0) & wr & (wa == rs);
  endfunction

  // Priority EX > MEM > WB > regfile; x0 reads as zero, unused sources pass rf data.
  function automatic logic [XLEN-1:0] pick_operand(input logic              used,
                                                   input logic [REG_AW-1:0] rs,
                                                   input logic [XLEN-1:0]   rf,
                                                   input logic              ex_use,
                                                   input logic              mem_use,
                                                   input logic              wb_use,
                                                   input logic [XLEN-1:0]   ex_d,
                                                   input logic [XLEN-1:0]   mem_d,
                                                   input logic [XLEN-1:0]   wb_d);
    logic [XLEN-1:0] val;
    val = rf;
    if (!used) begin
      val = rf;
    end else if (rs == '0) begin
      val = '0;
    end else if (ex_use) begin
      val = ex_d;
    end else if (mem_use) begin
      val = mem_d;
    end else if (wb_use) begin
      val = wb_d;
    end
    return val;
  endfunction

  // Dependency detection against the three in-flight producers.
  always_comb begin
    ex_src_write = ex_pipe_valid & ex_rd_write;
    ex_hit_rs1   = src_match(dec_rs1_read, dec_rs1_addr, ex_src_write, ex_rd_addr);
    ex_hit_rs2   = src_match(dec_rs2_read, dec_rs2_addr, ex_src_write, ex_rd_addr);
    mem_hit_rs1  = src_match(dec_rs1_read, dec_rs1_addr, mem_rd_write, mem_rd_addr);
    mem_hit_rs2  = src_match(dec_rs2_read, dec_rs2_addr, mem_rd_write, mem_rd_addr);
    wb_hit_rs1   = src_match(dec_rs1_read, dec_rs1_addr, wb_rd_write, wb_rd_addr);
    wb_hit_rs2   = src_match(dec_rs2_read, dec_rs2_addr, wb_rd_write, wb_rd_addr);
  end

  // A load result is not ready in EX; without EX forwarding any EX dependency stalls.
  always_comb begin
    ex_dep_stalls = ex_mem_read | ~EX_FWD_EN;
    hazard        = id_pipe_valid & (ex_hit_rs1 | ex_hit_rs2) & ex_dep_stalls;
    id_pipe_ready = flush | (ex_pipe_ready & ~hazard);
    stall_event   = id_pipe_valid & ~flush & ~id_pipe_ready;
  end

  always_comb begin
    rs1_value = pick_operand(dec_rs1_read, dec_rs1_addr, rf_rs1_rdata,
                             ex_hit_rs1 & ~ex_dep_stalls, mem_hit_rs1,
                             wb_hit_rs1 & WB_BYP_EN,
                             ex_fwd_data, mem_rd_wdata, wb_rd_wdata);
    rs2_value = pick_operand(dec_rs2_read, dec_rs2_addr, rf_rs2_rdata,
                             ex_hit_rs2 & ~ex_dep_stalls, mem_hit_rs2,
                             wb_hit_rs2 & WB_BYP_EN,
                             ex_fwd_data, mem_rd_wdata, wb_rd_wdata);
  end

  // ID/EX register: flush kills the slot, EX back-pressure holds everything.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      ex_pipe_valid  <= 1'b0;
      ex_pc          <= '0;
      ex_instruction <= '0;
      ex_immediate   <= '0;
      ex_ctrl        <= '0;
      ex_rs1_rdata   <= '0;
      ex_rs2_rdata   <= '0;
      ex_rd_write    <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_rd_addr     <= '0;
    end else if (flush) begin
      ex_pipe_valid  <= 1'b0;
    end else if (ex_pipe_ready) begin
      ex_pipe_valid  <= id_pipe_valid & ~hazard;
      ex_pc          <= id_pc;
      ex_instruction <= id_instruction;
      ex_immediate   <= dec_immediate;
      ex_ctrl        <= dec_ctrl;
      ex_rs1_rdata   <= rs1_value;
      ex_rs2_rdata   <= rs2_value;
      ex_rd_write    <= dec_rd_write;
      ex_mem_read    <= dec_mem_read;
      ex_rd_addr     <= dec_rd_addr;
    end
  end

  // Saturating count of cycles where a valid instruction could not leave ID.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      stall_cnt <= '0;
    end else if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage: two configurations driven by the same stimulus,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_id_hazard_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, id_pipe_valid, flush, ex_pipe_ready;
  logic [31:0] id_pc, id_instruction, dec_immediate, rf_rs1_rdata, rf_rs2_rdata;
  logic [23:0] dec_ctrl;
  logic        dec_rs1_read, dec_rs2_read, dec_rd_write, dec_mem_read;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [31:0] ex_fwd_data, mem_rd_wdata, wb_rd_wdata;
  logic        mem_rd_write, wb_rd_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;

  logic        d0_rdy, d0_v, d0_rdw, d0_ld, d1_rdy, d1_v, d1_rdw, d1_ld;
  logic [31:0] d0_pc, d0_instr, d0_imm, d0_op1, d0_op2;
  logic [31:0] d1_pc, d1_instr, d1_imm, d1_op1, d1_op2;
  logic [23:0] d0_ctrl, d1_ctrl;
  logic [4:0]  d0_rd, d1_rd;
  logic [31:0] d0_cnt;
  logic [1:0]  d1_cnt;

  id_hazard_stage u_dut0 (
    .clk(clk), .rst_b(rst_b), .id_pipe_valid(id_pipe_valid), .id_pipe_ready(d0_rdy),
    .id_pc(id_pc), .id_instruction(id_instruction), .dec_ctrl(dec_ctrl),
    .dec_rs1_read(dec_rs1_read), .dec_rs2_read(dec_rs2_read),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_write(dec_rd_write), .dec_rd_addr(dec_rd_addr), .dec_mem_read(dec_mem_read),
    .dec_immediate(dec_immediate), .rf_rs1_rdata(rf_rs1_rdata), .rf_rs2_rdata(rf_rs2_rdata),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_valid(d0_v), .ex_pc(d0_pc),
    .ex_instruction(d0_instr), .ex_immediate(d0_imm), .ex_ctrl(d0_ctrl),
    .ex_rs1_rdata(d0_op1), .ex_rs2_rdata(d0_op2), .ex_rd_write(d0_rdw),
    .ex_mem_read(d0_ld), .ex_rd_addr(d0_rd), .ex_fwd_data(ex_fwd_data),
    .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr), .mem_rd_wdata(mem_rd_wdata),
    .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .flush(flush), .stall_cnt(d0_cnt)
  );

  id_hazard_stage #(.EX_FWD(0), .WB_BYPASS(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .id_pipe_valid(id_pipe_valid), .id_pipe_ready(d1_rdy),
    .id_pc(id_pc), .id_instruction(id_instruction), .dec_ctrl(dec_ctrl),
    .dec_rs1_read(dec_rs1_read), .dec_rs2_read(dec_rs2_read),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_write(dec_rd_write), .dec_rd_addr(dec_rd_addr), .dec_mem_read(dec_mem_read),
    .dec_immediate(dec_immediate), .rf_rs1_rdata(rf_rs1_rdata), .rf_rs2_rdata(rf_rs2_rdata),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_valid(d1_v), .ex_pc(d1_pc),
    .ex_instruction(d1_instr), .ex_immediate(d1_imm), .ex_ctrl(d1_ctrl),
    .ex_rs1_rdata(d1_op1), .ex_rs2_rdata(d1_op2), .ex_rd_write(d1_rdw),
    .ex_mem_read(d1_ld), .ex_rd_addr(d1_rd), .ex_fwd_data(ex_fwd_data),
    .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr), .mem_rd_wdata(mem_rd_wdata),
    .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .flush(flush), .stall_cnt(d1_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in EX for each configuration, plus its stall count.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, instr, imm, op1, op2;
    logic [23:0] ctrl;
    logic        rdw, ld;
    logic [4:0]  rd;
  } ex_rec_t;

  ex_rec_t         m_ex  [2];
  longint unsigned m_cnt [2];

  // Configuration 0 forwards from EX and WB; configuration 1 does neither.
  function automatic bit cfg_exfwd(input int c);
    return c == 0;
  endfunction
  function automatic bit cfg_wbbyp(input int c);
    return c == 0;
  endfunction
  function automatic longint unsigned cfg_max(input int c);
    return (c == 0) ? 64'hFFFF_FFFF : 64'd3;
  endfunction

  function automatic bit ex_writes(input int c, input logic used, input logic [4:0] rs);
    return used && rs != 0 && m_ex[c].v && m_ex[c].rdw && m_ex[c].rd == rs;
  endfunction

  function automatic bit m_hazard(input int c);
    bool_dep: begin end
    return id_pipe_valid &&
           (ex_writes(c, dec_rs1_read, dec_rs1_addr) || ex_writes(c, dec_rs2_read, dec_rs2_addr)) &&
           (m_ex[c].ld || !cfg_exfwd(c));
  endfunction

  function automatic bit m_ready(input int c);
    return flush || (ex_pipe_ready && !m_hazard(c));
  endfunction

  function automatic logic [31:0] m_operand(input int c, input logic used, input logic [4:0] rs,
                                            input logic [31:0] rf);
    if (!used) return rf;
    if (rs == 0) return 32'd0;
    if (ex_writes(c, 1'b1, rs) && cfg_exfwd(c) && !m_ex[c].ld) return ex_fwd_data;
    if (mem_rd_write && mem_rd_addr == rs) return mem_rd_wdata;
    if (cfg_wbbyp(c) && wb_rd_write && wb_rd_addr == rs) return wb_rd_wdata;
    return rf;
  endfunction

  ex_rec_t nx;
  bit      m_rdy, m_hz;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst_b) begin
        m_ex[c]  = '0;
        m_cnt[c] = 0;
      end else begin
        m_rdy    = m_ready(c);
        m_hz     = m_hazard(c);
        nx.v     = id_pipe_valid && !m_hz;
        nx.pc    = id_pc;
        nx.instr = id_instruction;
        nx.imm   = dec_immediate;
        nx.ctrl  = dec_ctrl;
        nx.op1   = m_operand(c, dec_rs1_read, dec_rs1_addr, rf_rs1_rdata);
        nx.op2   = m_operand(c, dec_rs2_read, dec_rs2_addr, rf_rs2_rdata);
        nx.rdw   = dec_rd_write;
        nx.ld    = dec_mem_read;
        nx.rd    = dec_rd_addr;
        if (id_pipe_valid && !flush && !m_rdy && m_cnt[c] < cfg_max(c)) m_cnt[c] = m_cnt[c] + 1;
        if (flush) m_ex[c].v = 1'b0;
        else if (ex_pipe_ready) m_ex[c] = nx;
      end
    end
  end

  task automatic cmp_dut(input int c, input logic rdy, input logic v,
                         input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                         input logic [31:0] op1, input logic [31:0] op2, input logic [23:0] ctrl,
                         input logic rdw, input logic ld, input logic [4:0] rd,
                         input logic [63:0] cnt);
    string p;
    p = $sformatf("d%0d_", c);
    chk({p, "id_pipe_ready"}, 64'(rdy), 64'(m_ready(c)));
    chk({p, "ex_pipe_valid"}, 64'(v), 64'(m_ex[c].v));
    chk({p, "stall_cnt"}, cnt, m_cnt[c]);
    if (m_ex[c].v) begin
      chk({p, "ex_pc"}, 64'(pc), 64'(m_ex[c].pc));
      chk({p, "ex_instruction"}, 64'(instr), 64'(m_ex[c].instr));
      chk({p, "ex_immediate"}, 64'(imm), 64'(m_ex[c].imm));
      chk({p, "ex_ctrl"}, 64'(ctrl), 64'(m_ex[c].ctrl));
      chk({p, "ex_rs1_rdata"}, 64'(op1), 64'(m_ex[c].op1));
      chk({p, "ex_rs2_rdata"}, 64'(op2), 64'(m_ex[c].op2));
      chk({p, "ex_rd_write"}, 64'(rdw), 64'(m_ex[c].rdw));
      chk({p, "ex_mem_read"}, 64'(ld), 64'(m_ex[c].ld));
      chk({p, "ex_rd_addr"}, 64'(rd), 64'(m_ex[c].rd));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, d0_rdy, d0_v, d0_pc, d0_instr, d0_imm, d0_op1, d0_op2, d0_ctrl,
              d0_rdw, d0_ld, d0_rd, 64'(d0_cnt));
      cmp_dut(1, d1_rdy, d1_v, d1_pc, d1_instr, d1_imm, d1_op1, d1_op2, d1_ctrl,
              d1_rdw, d1_ld, d1_rd, 64'(d1_cnt));
    end
  end

  task automatic clear_inputs();
    rst_b = 1'b0; id_pipe_valid = 1'b0; flush = 1'b0; ex_pipe_ready = 1'b1;
    id_pc = '0; id_instruction = '0; dec_immediate = '0; dec_ctrl = '0;
    dec_rs1_read = 1'b0; dec_rs2_read = 1'b0; dec_rs1_addr = 5'd1; dec_rs2_addr = 5'd2;
    dec_rd_write = 1'b0; dec_rd_addr = '0; dec_mem_read = 1'b0;
    rf_rs1_rdata = '0; rf_rs2_rdata = '0; ex_fwd_data = '0;
    mem_rd_write = 1'b0; mem_rd_addr = '0; mem_rd_wdata = '0;
    wb_rd_write = 1'b0; wb_rd_addr = '0; wb_rd_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a producer instruction with no source reads.
  task automatic issue_producer(input logic [31:0] pc, input logic [4:0] rd, input logic ld);
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = pc; id_instruction = pc ^ 32'h0000_0013;
    dec_rd_write = 1'b1; dec_rd_addr = rd; dec_mem_read = ld;
  endtask

  initial begin
    clear_inputs();
    rst_b = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    chk("lit_reset_valid0", 64'(d0_v), 64'd0);
    chk("lit_reset_cnt0", 64'(d0_cnt), 64'd0);
    chk("lit_reset_pc0", 64'(d0_pc), 64'd0);
    chk("lit_reset_valid1", 64'(d1_v), 64'd0);
    rst_b = 1'b0;

    // Independent back-to-back instructions stream through with one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      issue_producer(32'h100 + 32'(4 * i), 5'(10 + i), 1'b0);
      step();
      chk("lit_b2b_valid", 64'(d0_v), 64'd1);
      chk("lit_b2b_pc", 64'(d0_pc), 64'h100 + 64'(4 * i));
    end
    chk("lit_b2b_cnt", 64'(d0_cnt), 64'd0);

    // EX has priority over MEM and WB; without EX forwarding a bubble then MEM data.
    issue_producer(32'h200, 5'd5, 1'b0);
    step();
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = 32'h204; dec_rs1_read = 1'b1; dec_rs1_addr = 5'd5;
    ex_fwd_data = 32'h1234; rf_rs1_rdata = 32'h9999;
    mem_rd_write = 1'b1; mem_rd_addr = 5'd5; mem_rd_wdata = 32'hAAAA;
    wb_rd_write = 1'b1; wb_rd_addr = 5'd5; wb_rd_wdata = 32'hBBBB;
    #1;
    chk("lit_exprio_ready0", 64'(d0_rdy), 64'd1);
    chk("lit_exprio_ready1", 64'(d1_rdy), 64'd0);
    step();
    chk("lit_exprio_op1", 64'(d0_op1), 64'h1234);
    chk("lit_exprio_valid0", 64'(d0_v), 64'd1);
    chk("lit_nofwd_bubble", 64'(d1_v), 64'd0);
    chk("lit_nofwd_cnt", 64'(d1_cnt), 64'd1);
    step();
    chk("lit_nofwd_valid", 64'(d1_v), 64'd1);
    chk("lit_nofwd_op1", 64'(d1_op1), 64'hAAAA);
    chk("lit_nofwd_cnt_hold", 64'(d1_cnt), 64'd1);

    // Load-use: one bubble, then the MEM forward supplies the loaded value.
    issue_producer(32'h300, 5'd7, 1'b1);
    step();
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = 32'h304; dec_rs2_read = 1'b1; dec_rs2_addr = 5'd7;
    rf_rs2_rdata = 32'h5555;
    #1;
    chk("lit_lduse_ready", 64'(d0_rdy), 64'd0);
    step();
    chk("lit_lduse_bubble", 64'(d0_v), 64'd0);
    chk("lit_lduse_cnt", 64'(d0_cnt), 64'd1);
    mem_rd_write = 1'b1; mem_rd_addr = 5'd7; mem_rd_wdata = 32'hDEAD;
    #1;
    chk("lit_lduse_ready2", 64'(d0_rdy), 64'd1);
    step();
    chk("lit_lduse_valid", 64'(d0_v), 64'd1);
    chk("lit_lduse_op2", 64'(d0_op2), 64'hDEAD);

    // x0 reads zero even when every stage writes x0.
    issue_producer(32'h400, 5'd0, 1'b0);
    step();
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = 32'h404; dec_rs1_read = 1'b1; dec_rs1_addr = 5'd0;
    ex_fwd_data = 32'hFFFF; rf_rs1_rdata = 32'hFFFF;
    mem_rd_write = 1'b1; mem_rd_addr = 5'd0; mem_rd_wdata = 32'hFFFF;
    wb_rd_write = 1'b1; wb_rd_addr = 5'd0; wb_rd_wdata = 32'hFFFF;
    #1;
    chk("lit_x0_ready0", 64'(d0_rdy), 64'd1);
    chk("lit_x0_ready1", 64'(d1_rdy), 64'd1);
    step();
    chk("lit_x0_op1_d0", 64'(d0_op1), 64'd0);
    chk("lit_x0_op1_d1", 64'(d1_op1), 64'd0);

    // EX back-pressure for three cycles holds the ID/EX register.
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = 32'h500; ex_pipe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_bp_ready", 64'(d0_rdy), 64'd0);
      step();
      chk("lit_bp_pc", 64'(d0_pc), 64'h404);
      chk("lit_bp_valid", 64'(d0_v), 64'd1);
    end
    chk("lit_bp_cnt", 64'(d0_cnt), 64'd4);

    // Flush during a load-use hazard wins: accept, kill EX, no stall counted.
    issue_producer(32'h600, 5'd7, 1'b1);
    step();
    clear_inputs();
    id_pipe_valid = 1'b1; id_pc = 32'h604; dec_rs1_read = 1'b1; dec_rs1_addr = 5'd7;
    flush = 1'b1;
    #1;
    chk("lit_flush_ready", 64'(d0_rdy), 64'd1);
    step();
    chk("lit_flush_valid", 64'(d0_v), 64'd0);
    chk("lit_flush_cnt", 64'(d0_cnt), 64'd4);

    // Two-bit counter saturates at 3 after five stalled cycles and holds.
    clear_inputs();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0; id_pipe_valid = 1'b1; ex_pipe_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("lit_sat_cnt1", 64'(d1_cnt), 64'd3);
    chk("lit_sat_cnt0", 64'(d0_cnt), 64'd5);
    id_pipe_valid = 1'b0;
    step();
    chk("lit_sat_hold1", 64'(d1_cnt), 64'd3);

    // Randomised traffic over a small register set to provoke dependencies.
    for (int i = 0; i < 3000; i++) begin
      rst_b          = ($urandom_range(0, 199) == 0);
      id_pipe_valid  = ($urandom_range(0, 9) < 8);
      flush          = ($urandom_range(0, 19) == 0);
      ex_pipe_ready  = ($urandom_range(0, 9) < 8);
      id_pc          = $urandom;
      id_instruction = $urandom;
      dec_immediate  = $urandom;
      dec_ctrl       = 24'($urandom);
      dec_rs1_read   = 1'($urandom);
      dec_rs2_read   = 1'($urandom);
      dec_rs1_addr   = dec_rs1_read ? 5'($urandom_range(0, 3)) : 5'($urandom_range(1, 3));
      dec_rs2_addr   = dec_rs2_read ? 5'($urandom_range(0, 3)) : 5'($urandom_range(1, 3));
      dec_rd_write   = ($urandom_range(0, 3) != 0);
      dec_rd_addr    = 5'($urandom_range(0, 3));
      dec_mem_read   = ($urandom_range(0, 3) == 0);
      rf_rs1_rdata   = $urandom;
      rf_rs2_rdata   = $urandom;
      ex_fwd_data    = $urandom;
      mem_rd_write   = 1'($urandom);
      mem_rd_addr    = 5'($urandom_range(0, 3));
      mem_rd_wdata   = $urandom;
      wb_rd_write    = 1'($urandom);
      wb_rd_addr     = 5'($urandom_range(0, 3));
      wb_rd_wdata    = $urandom;
      step();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_stage.md
Name: id_hazard_stage

Overview:
- Parametrised next-generation instruction-decode pipeline stage. Sits between IF and EX.
- Takes decoded fields from the decoder and raw regfile read data.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and inserts load-use bubbles.
- Honours ID/EX valid/ready back-pressure, supports pipeline flush, and keeps a stall performance counter.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width; register 0 is hardwired zero
CTRL_W, 24, width of opaque decoded control bundle (alu/branch/jump/mem opcodes) passed through to EX
EX_FWD, 1, 1 = forward from EX-stage result; 0 = any EX-stage RAW hazard stalls
WB_BYPASS, 1, 1 = forward WB write data in the same cycle (regfile is write-then-read unsafe)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst_b  in  1  synchronous active-high reset
id_pipe_valid  in  1  IF->ID instruction valid
id_pipe_ready  out  1  ID can accept instruction
id_pc, id_instruction  in  XLEN each  PC / raw instruction
dec_ctrl  in  CTRL_W  decoded control bundle
dec_rs1_read, dec_rs2_read  in  1 each  source operand used
dec_rs1_addr, dec_rs2_addr  in  REG_AW each  source register
dec_rd_write  in  1  instruction writes rd
dec_rd_addr  in  REG_AW  destination register
dec_mem_read  in  1  instruction is a load
dec_immediate  in  XLEN  decoded immediate
rf_rs1_rdata, rf_rs2_rdata  in  XLEN each  regfile combinational read data
ex_pipe_ready  in  1  EX accepts
ex_pipe_valid  out  1  ID->EX valid
ex_pc, ex_instruction, ex_immediate  out  XLEN each  registered pass-through
ex_ctrl  out  CTRL_W  registered control bundle
ex_rs1_rdata, ex_rs2_rdata  out  XLEN each  resolved operands
ex_rd_write, ex_mem_read  out  1 each  registered
ex_rd_addr  out  REG_AW  registered
ex_fwd_data  in  XLEN  combinational result of the instruction currently in EX
mem_rd_write  in  1  MEM-stage instruction valid and writes rd
mem_rd_addr  in  REG_AW  MEM-stage destination register
mem_rd_wdata  in  XLEN  MEM-stage final write data
wb_rd_write  in  1  WB write enable
wb_rd_addr  in  REG_AW  WB destination register
wb_rd_wdata  in  XLEN  WB write data
flush  in  1  kill the ID instruction and the ID/EX register contents
stall_cnt  out  CNT_W  stall cycle count

Behaviour:
- Reset (rst_b=1 at posedge): ex_pipe_valid=0, all ex_* data/control = 0, stall_cnt=0. id_pipe_ready follows its combinational equation.
- Match rules:
  - match_X(rs) = dec_rsN_read & rs!=0 & X_write & X_addr==rs.
  - EX source write = ex_pipe_valid & ex_rd_write.
- Hazard:
  - hazard = id_pipe_valid & (EX match on rs1 or rs2) & (ex_mem_read | EX_FWD==0).
- Operand select, per source, priority EX > MEM > WB > RF:
  - EX match (non-load, EX_FWD=1): ex_fwd_data.
  - MEM match: mem_rd_wdata.
  - WB match and WB_BYPASS=1: wb_rd_wdata.
  - Otherwise: rf_rsN_rdata.
  - Address 0 always yields 0, regardless of rf data.
  - Sources with dec_rsN_read=0 pass rf data unchanged and never cause a hazard.
- Handshake:
  - id_pipe_ready = flush | (ex_pipe_ready & ~hazard).
  - ID instruction is consumed when id_pipe_valid & id_pipe_ready.
- ID/EX register update:
  - flush: ex_pipe_valid<=0. Data registers are don't-care but held. Flush overrides hazard and ex_pipe_ready=0.
  - else if ex_pipe_ready: ex_pipe_valid <= id_pipe_valid & ~hazard; load all ex_* data from ID.
    - hazard with ex_pipe_ready=1 inserts exactly one bubble per cycle.
  - else: hold all ex_* registers (no data change while EX stalls).
- Latency: 1 cycle ID->EX when no hazard.
- Load-use stall duration: 1 cycle with a single-cycle EX. When the load advances to MEM, the MEM forward supplies its data.
- stall_cnt: +1 each cycle with id_pipe_valid & ~flush & ~id_pipe_ready.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Reset mid-stall: ex_pipe_valid=0 next cycle; the pending instruction is re-presented by IF.

Test Plan:
- Reset then back-to-back ADDs with no dependence, ex_pipe_ready=1 -> ex_pipe_valid=1 every cycle from cycle 1, ex_pc follows id_pc with 1-cycle lag, stall_cnt=0.
- EX holds non-load rd=x5 (ex_fwd_data=0x1234); ID reads rs1=x5; MEM and WB also write x5 with 0xAAAA and 0xBBBB -> ex_rs1_rdata=0x1234 (EX priority), no stall. Same case with EX_FWD=0 -> 1 bubble, stall_cnt=1, operand then 0xAAAA.
- EX holds load rd=x7; ID reads rs2=x7 -> id_pipe_ready=0 for 1 cycle, bubble (ex_pipe_valid=0); next cycle mem_rd_wdata=0xDEAD forwarded to ex_rs2_rdata.
- ID reads rs1=x0 while EX, MEM and WB all write x0 with 0xFFFF -> ex_rs1_rdata=0, no stall.
- ex_pipe_ready=0 for 3 cycles while ID valid -> ex_* registers unchanged, id_pipe_ready=0, stall_cnt increments by 3.
- flush asserted during a load-use hazard -> id_pipe_ready=1, ex_pipe_valid=0 next cycle, stall_cnt unchanged. With CNT_W=2 and 5 stalled cycles -> stall_cnt=3, held.
